// File: rtl/fft_frame_unloader.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_unloader
// Brief    : Captures parallel FFT result frames into a two-deep buffer
//            (active + pending) and streams them one word per beat over a
//            valid/ready interface, optionally in bit-reversed index order.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_unloader #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 64,
  parameter int IDXW   = 6,
  parameter bit BITREV = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NWORDS*WIDTH-1:0] frame_in,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic [IDXW-1:0]         m_index,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int              c_FRAME_W   = NWORDS * WIDTH;
  localparam logic [IDXW-1:0] c_LAST_BEAT = IDXW'(NWORDS - 1);

  // Buffer occupancy doubles as the control state.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_STREAM  = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_FRAME_W-1:0]  r_active;
  logic [c_FRAME_W-1:0]  r_pending;
  logic [c_FRAME_W-1:0]  w_src;
  logic [IDXW-1:0]       r_beat;
  logic [IDXW-1:0]       w_beat_nxt;
  logic [IDXW-1:0]       w_word_idx;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic [WIDTH-1:0]      r_m_data;
  logic [IDXW-1:0]       r_m_index;
  logic                  r_overflow;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_hs;
  logic                  w_last_hs;
  logic                  w_present;
  logic                  w_load_active_in;
  logic                  w_load_active_pend;
  logic                  w_load_pending;

  // Mirror the bit order of a beat number to get its source word index.
  function automatic logic [IDXW-1:0] f_bitrev(input logic [IDXW-1:0] k);
    logic [IDXW-1:0] r;
    r = '0;
    for (int b = 0; b < IDXW; b++) begin
      r[b] = k[IDXW-1-b];
    end
    return r;
  endfunction

  // Ready depends only on registered occupancy, never on m_ready.
  assign frame_ready = (r_state == ST_EMPTY) || (r_state == ST_STREAM);
  assign w_accept    = frame_valid && frame_ready;
  assign w_drop      = frame_valid && !frame_ready;
  assign w_hs        = r_m_valid && m_ready;
  assign w_last_hs   = w_hs && (r_beat == c_LAST_BEAT);

  // Decide next occupancy, next beat, and which buffer feeds the next beat.
  always_comb begin
    w_state_nxt        = r_state;
    w_beat_nxt         = r_beat;
    w_src              = r_active;
    w_present          = 1'b0;
    w_load_active_in   = 1'b0;
    w_load_active_pend = 1'b0;
    w_load_pending     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_active_in = 1'b1;
          w_src            = frame_in;
          w_present        = 1'b1;
          w_beat_nxt       = '0;
          w_state_nxt      = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_last_hs) begin
          w_beat_nxt = '0;
          if (w_accept) begin
            // New frame bypasses pending and follows without a bubble.
            w_load_active_in = 1'b1;
            w_src            = frame_in;
            w_present        = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end else begin
          if (w_hs) begin
            w_beat_nxt = r_beat + 1'b1;
            w_present  = 1'b1;
          end
          if (w_accept) begin
            w_load_pending = 1'b1;
            w_state_nxt    = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (w_last_hs) begin
          w_beat_nxt         = '0;
          w_src              = r_pending;
          w_present          = 1'b1;
          w_load_active_pend = 1'b1;
          w_state_nxt        = ST_STREAM;
        end else if (w_hs) begin
          w_beat_nxt = r_beat + 1'b1;
          w_present  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  assign w_word_idx = BITREV ? f_bitrev(w_beat_nxt) : w_beat_nxt;

  // Control state and registered stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_EMPTY;
      r_beat    <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_index <= '0;
      r_m_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      if (w_present) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_src[w_word_idx*WIDTH +: WIDTH];
        r_m_index <= w_word_idx;
        r_m_last  <= (w_beat_nxt == c_LAST_BEAT);
      end else if (w_last_hs) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  // Frame storage; contents are meaningless while occupancy says empty.
  always_ff @(posedge clk) begin
    if (w_load_active_in) begin
      r_active <= frame_in;
    end else if (w_load_active_pend) begin
      r_active <= r_pending;
    end
    if (w_load_pending) begin
      r_pending <= frame_in;
    end
  end

  // Sticky drop flag; a new drop takes priority over a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_index  = r_m_index;
  assign m_last   = r_m_last;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
